// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 9;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WAIT_WORD,
      ST_SETUP,
      ST_ACK_HI,
      ST_ACK_LO,
      ST_RB_HI,
      ST_RB_LO,
      ST_DONE,
      ST_ERROR
   } state_t;

   // Dual-rail read_Nwrite encodings
   localparam logic [1:0] RW_SPACER = 2'b00;
   localparam logic [1:0] RW_WRITE  = 2'b01;
   localparam logic [1:0] RW_READ   = 2'b10;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;
   localparam logic [1:0] ERR_VERIFY   = 2'b11;

endpackage

// File: rtl/prog_loader_ack_sync.sv
// Multi-flop synchroniser for an asynchronous acknowledge, cleared on reset.
module ack_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/prog_loader.sv
// Streams host words into the async memory over its 4-phase write port, then releases the core.
// Build option: PROG_LOADER_READBACK_EN adds a verify read after every write.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned MAX_WORDS   = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic [1:0]        mem_rw,
   input  logic              mem_ack_write,
   input  logic              mem_ack_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  word_count
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_WORDS);

   state_t            r_state, w_state_nxt;
   logic              r_s_ready, w_s_ready_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_mem_data, w_data_nxt;
   logic [1:0]        r_mem_rw, w_rw_nxt;
   logic              r_cpu_rst_n, w_cpu_rst_n_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_err, w_err_nxt;
   logic [1:0]        r_err_code, w_code_nxt;
   logic [CNT_W-1:0]  r_word_cnt, w_cnt_nxt, w_cnt_inc;
   logic              r_last, w_last_nxt;
   logic [TO_W-1:0]   r_to_cnt, w_to_nxt, w_to_inc;
   logic              w_commit, w_fail;
   logic [1:0]        w_fail_code;
   logic              w_ack_wr, w_ack_rd;

   ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (mem_ack_write),
      .o_q   (w_ack_wr)
   );

   ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (mem_ack_read),
      .o_q   (w_ack_rd)
   );

`ifndef PROG_LOADER_READBACK_EN
   logic w_unused;
   assign w_unused = ^{w_ack_rd, mem_rdata};
`endif

   assign w_cnt_inc = r_word_cnt + CNT_W'(1);
   assign w_to_inc  = r_to_cnt + TO_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_ready   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_mem_rw    <= RW_SPACER;
         r_cpu_rst_n <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_word_cnt  <= '0;
         r_last      <= 1'b0;
         r_to_cnt    <= '0;
      end else begin
         r_s_ready   <= w_s_ready_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_mem_data  <= w_data_nxt;
         r_mem_rw    <= w_rw_nxt;
         r_cpu_rst_n <= w_cpu_rst_n_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         r_err_code  <= w_code_nxt;
         r_word_cnt  <= w_cnt_nxt;
         r_last      <= w_last_nxt;
         r_to_cnt    <= w_to_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_s_ready_nxt   = r_s_ready;
      w_addr_nxt      = r_mem_addr;
      w_data_nxt      = r_mem_data;
      w_rw_nxt        = r_mem_rw;
      w_cpu_rst_n_nxt = r_cpu_rst_n;
      w_busy_nxt      = r_busy;
      w_done_nxt      = r_done;
      w_err_nxt       = r_err;
      w_code_nxt      = r_err_code;
      w_cnt_nxt       = r_word_cnt;
      w_last_nxt      = r_last;
      w_to_nxt        = '0;
      w_commit        = 1'b0;
      w_fail          = 1'b0;
      w_fail_code     = ERR_NONE;

      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            w_rw_nxt        = RW_SPACER;
            w_s_ready_nxt   = 1'b0;
            w_cpu_rst_n_nxt = (r_state == ST_DONE);
            if (load_start) begin
               w_state_nxt     = ST_WAIT_WORD;
               w_addr_nxt      = base_addr;
               w_cnt_nxt       = '0;
               w_busy_nxt      = 1'b1;
               w_done_nxt      = 1'b0;
               w_err_nxt       = 1'b0;
               w_code_nxt      = ERR_NONE;
               w_s_ready_nxt   = 1'b1;
               w_cpu_rst_n_nxt = 1'b0;
            end
         end
         ST_WAIT_WORD: begin
            if (s_valid && r_s_ready) begin
               w_data_nxt    = s_data;
               w_last_nxt    = s_last;
               w_s_ready_nxt = 1'b0;
               w_state_nxt   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_rw_nxt    = RW_WRITE;
            w_state_nxt = ST_ACK_HI;
         end
         ST_ACK_HI: begin
            w_to_nxt = w_to_inc;
            if (w_ack_wr) begin
               w_rw_nxt    = RW_SPACER;
               w_to_nxt    = '0;
               w_state_nxt = ST_ACK_LO;
            end else if (w_to_inc == TO_LIM) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_TIMEOUT;
            end
         end
         ST_ACK_LO: begin
            w_to_nxt = w_to_inc;
            if (!w_ack_wr) begin
`ifdef PROG_LOADER_READBACK_EN
               w_rw_nxt    = RW_READ;
               w_to_nxt    = '0;
               w_state_nxt = ST_RB_HI;
`else
               w_commit = 1'b1;
`endif
            end else if (w_to_inc == TO_LIM) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_TIMEOUT;
            end
         end
`ifdef PROG_LOADER_READBACK_EN
         ST_RB_HI: begin
            w_to_nxt = w_to_inc;
            if (w_ack_rd) begin
               w_rw_nxt = RW_SPACER;
               w_to_nxt = '0;
               if (mem_rdata != r_mem_data) begin
                  w_fail      = 1'b1;
                  w_fail_code = ERR_VERIFY;
               end else begin
                  w_state_nxt = ST_RB_LO;
               end
            end else if (w_to_inc == TO_LIM) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_TIMEOUT;
            end
         end
         ST_RB_LO: begin
            w_to_nxt = w_to_inc;
            if (!w_ack_rd) begin
               w_commit = 1'b1;
            end else if (w_to_inc == TO_LIM) begin
               w_fail      = 1'b1;
               w_fail_code = ERR_TIMEOUT;
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Word fully handshaken: advance, then finish, overflow or fetch the next word
      if (w_commit) begin
         w_cnt_nxt  = w_cnt_inc;
         w_addr_nxt = r_mem_addr + ADDR_W'(1);
         w_to_nxt   = '0;
         if (r_last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
         end else if (w_cnt_inc == CNT_LIM) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_OVERFLOW;
         end else begin
            w_state_nxt   = ST_WAIT_WORD;
            w_s_ready_nxt = 1'b1;
         end
      end

      if (w_fail) begin
         w_state_nxt     = ST_ERROR;
         w_err_nxt       = 1'b1;
         w_code_nxt      = w_fail_code;
         w_busy_nxt      = 1'b0;
         w_rw_nxt        = RW_SPACER;
         w_cpu_rst_n_nxt = 1'b0;
         w_s_ready_nxt   = 1'b0;
         w_to_nxt        = '0;
      end
   end

   assign s_ready    = r_s_ready;
   assign mem_addr   = r_mem_addr;
   assign mem_data   = r_mem_data;
   assign mem_rw     = r_mem_rw;
   assign cpu_rst_n  = r_cpu_rst_n;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign err_code   = r_err_code;
   assign word_count = r_word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a behavioural 4-phase async memory model.
module tb_prog_loader;

   localparam int unsigned TO_CYC = 20;
   localparam int unsigned MAXW   = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        s_last = 1'b0;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic [1:0]  mem_rw;
   logic        mem_ack_write;
   logic        mem_ack_read;
   logic [15:0] mem_rdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [8:0]  word_count;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [15:0] mem [256];
   int          n_writes = 0;
   int          n_reads = 0;
   int          corrupt_at = 0;
   bit          mem_noack = 1'b0;

   prog_loader #(
      .SYNC_STAGES (2),
      .TIMEOUT_CYC (TO_CYC),
      .MAX_WORDS   (MAXW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (load_start),
      .base_addr     (base_addr),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_last        (s_last),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .mem_rw        (mem_rw),
      .mem_ack_write (mem_ack_write),
      .mem_ack_read  (mem_ack_read),
      .mem_rdata     (mem_rdata),
      .cpu_rst_n     (cpu_rst_n),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_code      (err_code),
      .word_count    (word_count)
   );

   always #5 clk = ~clk;

   // Async memory: responds 3 cycles after each request/spacer transition
   initial begin
      int m_cnt;
      m_cnt = 0;
      mem_ack_write = 1'b0;
      mem_ack_read  = 1'b0;
      mem_rdata     = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            mem_ack_write = 1'b0;
            mem_ack_read  = 1'b0;
            m_cnt = 0;
         end else if (mem_rw == 2'b01 && !mem_ack_write && !mem_ack_read) begin
            if (!mem_noack) begin
               m_cnt++;
               if (m_cnt >= 3) begin
                  mem[mem_addr] = mem_data;
                  n_writes++;
                  mem_ack_write = 1'b1;
                  m_cnt = 0;
               end
            end
         end else if (mem_rw == 2'b10 && !mem_ack_read && !mem_ack_write) begin
            m_cnt++;
            if (m_cnt >= 3) begin
               n_reads++;
               mem_rdata = mem[mem_addr] ^ ((n_reads == corrupt_at) ? 16'h0001 : 16'h0000);
               mem_ack_read = 1'b1;
               m_cnt = 0;
            end
         end else if (mem_rw == 2'b00 && (mem_ack_write || mem_ack_read)) begin
            m_cnt++;
            if (m_cnt >= 3) begin
               mem_ack_write = 1'b0;
               mem_ack_read  = 1'b0;
               m_cnt = 0;
            end
         end else begin
            m_cnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_load(input logic [7:0] base);
      @(negedge clk);
      base_addr  = base;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send_word(input string tag, input logic [15:0] d, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(s_ready), 64'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(done || err) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(done || err), 64'd1);
   endtask

   task automatic wait_write_req(input string tag);
      int n;
      n = 0;
      while (mem_rw != 2'b01 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(mem_rw), 64'd1);
   endtask

   initial begin
      int w0;
      int elapsed;
      bit saw_ready;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_outputs", {s_ready, mem_addr, mem_data, mem_rw, cpu_rst_n, busy, done, err,
                            err_code, word_count}, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic load at 0x10
      w0 = n_writes;
      start_load(8'h10);
      check("basic_busy", 64'(busy), 64'd1);
      send_word("basic_w0", 16'hA001, 1'b0);
      send_word("basic_w1", 16'hB002, 1'b0);
      send_word("basic_w2", 16'hC003, 1'b1);
      wait_end("basic_end");
      check("basic_done", {done, err, busy}, 64'b100);
      check("basic_cpu_rst_lo", 64'(cpu_rst_n), 64'd0);
      check("basic_count", 64'(word_count), 64'd3);
      check("basic_mem", {mem[8'h10], mem[8'h11], mem[8'h12]}, 64'hA001_B002_C003);
      check("basic_nwr", 64'(n_writes - w0), 64'd3);
      check("basic_addr", 64'(mem_addr), 64'h13);
      @(negedge clk);
      check("basic_cpu_rst_hi", 64'(cpu_rst_n), 64'd1);

      // Address wrap from 0xFE
      start_load(8'hFE);
      check("wrap_restart", {done, cpu_rst_n, busy}, 64'b001);
      send_word("wrap_w0", 16'h1111, 1'b0);
      send_word("wrap_w1", 16'h2222, 1'b0);
      send_word("wrap_w2", 16'h3333, 1'b1);
      wait_end("wrap_end");
      check("wrap_status", {done, err, err_code}, 64'b1000);
      check("wrap_mem", {mem[8'hFE], mem[8'hFF], mem[8'h00]}, 64'h1111_2222_3333);
      check("wrap_addr", 64'(mem_addr), 64'h01);

      // Timeout: memory never acknowledges
      mem_noack = 1'b1;
      start_load(8'h40);
      send_word("to_w0", 16'h1234, 1'b1);
      wait_write_req("to_req");
      elapsed = 0;
      while (!err && elapsed < 500) begin
         @(negedge clk);
         elapsed++;
      end
      check("to_cycles", 64'(elapsed), 64'(TO_CYC));
      check("to_status", {err, err_code, mem_rw, cpu_rst_n, busy, done}, 64'b1_01_00_000);
      mem_noack = 1'b0;
      repeat (2) @(negedge clk);

      // Overflow: four words fill MAX_WORDS, fifth is never accepted
      w0 = n_writes;
      start_load(8'h80);
      check("ovf_clear", {err, err_code, busy, s_ready}, 64'b0_00_11);
      send_word("ovf_w0", 16'h0A0A, 1'b0);
      send_word("ovf_w1", 16'h0B0B, 1'b0);
      send_word("ovf_w2", 16'h0C0C, 1'b0);
      send_word("ovf_w3", 16'h0D0D, 1'b0);
      s_valid = 1'b1;
      s_data  = 16'h0E0E;
      s_last  = 1'b1;
      saw_ready = 1'b0;
      elapsed = 0;
      while (!err && elapsed < 500) begin
         @(negedge clk);
         if (s_ready) saw_ready = 1'b1;
         elapsed++;
      end
      repeat (3) begin
         @(negedge clk);
         if (s_ready) saw_ready = 1'b1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("ovf_status", {err, err_code}, 64'b1_10);
      check("ovf_count", 64'(word_count), 64'd4);
      check("ovf_nwr", 64'(n_writes - w0), 64'd4);
      check("ovf_no_ready", 64'(saw_ready), 64'd0);

      // Reset mid-handshake
      start_load(8'h20);
      send_word("mid_w0", 16'h5555, 1'b0);
      wait_write_req("mid_req");
      #3 rst_n = 1'b0;
      #1 check("mid_rw", 64'(mem_rw), 64'd0);
      check("mid_outputs", {s_ready, mem_addr, mem_data, mem_rw, cpu_rst_n, busy, done, err,
                            err_code, word_count}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Fresh load after reset
      start_load(8'h30);
      send_word("fresh_w0", 16'hDEAD, 1'b0);
      send_word("fresh_w1", 16'hBEEF, 1'b1);
      wait_end("fresh_end");
      check("fresh_status", {done, err, word_count}, {2'b10, 9'd2});
      check("fresh_mem", {mem[8'h30], mem[8'h31]}, 64'hDEAD_BEEF);

`ifdef PROG_LOADER_READBACK_EN
      // Readback verify: second word reads back with bit 0 flipped
      corrupt_at = n_reads + 2;
      start_load(8'h50);
      send_word("rb_w0", 16'h7770, 1'b0);
      send_word("rb_w1", 16'h8880, 1'b0);
      wait_end("rb_end");
      check("rb_status", {err, err_code, done}, 64'b1_11_0);
      check("rb_count", 64'(word_count), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Clocked boot-time program loader that sits directly upstream of the asynchronous memory.
- Accepts 16-bit instruction words from a host over a valid/ready stream.
- Writes each word into the memory through its bundled-data 4-phase write port: addr, data_in, dual-rail read_Nwrite, ack_write.
- Holds the asynchronous core in reset until the whole image is loaded, then releases it.

Parameters:
- SYNC_STAGES, 2, flops in the ack synchroniser chains (minimum 2).
- TIMEOUT_CYC, 255, clk cycles allowed for each ack edge before declaring a timeout.
- MAX_WORDS, 256, maximum words per load; must be at most 2^8.

Ports:
- clk  in  1  loader clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begins a load at base_addr.
- base_addr  in  8  first memory address of the image.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts the word this cycle.
- s_data  in  16  host word.
- s_last  in  1  marks the final word of the image.
- mem_addr  out  8  memory address (bundled data).
- mem_data  out  16  memory write data (bundled data).
- mem_rw  out  2  dual-rail read_Nwrite: 00 spacer, 01 write, 10 read, 11 illegal.
- mem_ack_write  in  1  asynchronous write acknowledge from memory.
- mem_ack_read  in  1  asynchronous read acknowledge (used only with readback).
- mem_rdata  in  16  memory read data (used only with readback).
- cpu_rst_n  out  1  reset to the asynchronous core.
- busy  out  1  load in progress.
- done  out  1  image loaded successfully.
- err  out  1  load aborted.
- err_code  out  2  00 none, 01 timeout, 10 overflow, 11 verify mismatch.
- word_count  out  9  words written in the current load.

Behaviour:
- Reset values: s_ready=0, mem_addr=0, mem_data=0, mem_rw=00, cpu_rst_n=0, busy=0, done=0, err=0, err_code=00, word_count=0. FSM goes to IDLE.
- All outputs are registered. mem_ack_write and mem_ack_read each pass through a SYNC_STAGES-flop synchroniser before use; the FSM only sees the synchronised versions.
- IDLE: cpu_rst_n=0. On load_start: capture base_addr, clear word_count, busy=1, go to WAIT_WORD.
- WAIT_WORD: s_ready=1. On s_valid: latch mem_addr and mem_data, latch s_last, s_ready drops next cycle, go to SETUP.
- SETUP: one cycle with mem_rw=00 so address/data are stable before the request. Next cycle mem_rw=01, go to ACK_HI.
- ACK_HI: hold mem_rw=01 until synchronised ack_write=1. Then mem_rw=00, go to ACK_LO.
- ACK_LO: wait for synchronised ack_write=0. Then increment word_count and mem_addr (8-bit wrap, 0xFF→0x00).
  - If the latched s_last is set: go to DONE.
  - Else if word_count has reached MAX_WORDS: go to ERROR with code 10.
  - Else: go to WAIT_WORD.
- mem_addr and mem_data must not change while mem_rw≠00 or while the synchronised ack is high.
- Timeout: a per-state counter resets on entry to ACK_HI and ACK_LO (and the readback states). If it reaches TIMEOUT_CYC: mem_rw=00, go to ERROR with code 01.
- DONE: busy=0, done=1. cpu_rst_n=1 one cycle after entry and stays high.
- ERROR: busy=0, err=1, cpu_rst_n=0, mem_rw=00.
- load_start in DONE or ERROR: clear done/err/err_code, cpu_rst_n=0 (registered), restart at WAIT_WORD.
- load_start while busy is ignored.
- Latency per word from acceptance: 1 (SETUP) + 1 + synchroniser delay per ack edge + memory response.
- Asynchronous reset mid-handshake forces mem_rw=00 immediately; the memory is expected to return its ack to 0 on its own rst_n.

Optional Feature:
- Macro PROG_LOADER_READBACK_EN.
- Defined: after each ACK_LO, the loader runs RB_HI (mem_rw=10, wait synchronised ack_read=1), compares mem_rdata with the latched data, then RB_LO (mem_rw=00, wait ack_read=0).
  - Mismatch goes to ERROR with code 11.
  - word_count increments only after a successful readback.
- Undefined: no readback states; mem_ack_read and mem_rdata are unused; code 11 is never produced.

Decomposition:
- Package prog_loader_pkg holds:
  - FSM state enum;
  - dual-rail constants RW_SPACER=2'b00, RW_WRITE=2'b01, RW_READ=2'b10;
  - err_code constants.
- One natural sub-module: ack_sync, a parameterised SYNC_STAGES flop chain with asynchronous clear. It is instantiated once per ack.

Test Plan:
- Basic load: base_addr=0x10, three words 0xA001, 0xB002, 0xC003 (last on the third), memory model acks after 3 cycles → memory holds them at 0x10..0x12, word_count=3, done=1, cpu_rst_n rises one cycle after done.
- Address wrap: base_addr=0xFE, three words → writes to 0xFE, 0xFF, 0x00; no error.
- Timeout: memory never raises ack_write → after TIMEOUT_CYC+sync cycles, err=1, err_code=01, mem_rw=00, cpu_rst_n=0.
- Overflow with MAX_WORDS=4: five words with s_last only on the fifth → four writes, then err_code=10; the fifth word is never accepted (s_ready stays low).
- Reset mid-handshake: assert rst_n low during ACK_HI → mem_rw=00 within the same cycle, all outputs return to reset values; a fresh load_start then completes normally.
- With PROG_LOADER_READBACK_EN, memory model corrupts bit 0 on readback of the second word → err_code=11, word_count=1.
